cp0_ctrl: RTL

Parametrised coprocessor-0 for the pipelined MIPS CPU. It holds the SR, Cause, EPC and PRId registers. It arbitrates hardware interrupts against synchronous exceptions, masking each interrupt line through SR.IM and gating all of them with SR.IE and SR.EXL. It sits beside the M stage, takes exception and interrupt requests, and returns the handler-entry request and EPC to the PC logic.
- Generalises the previous CP0 with: configurable interrupt count, IM/IE masking, a distinct eret handshake, correct EPC on delay slots, and an optional Count/Compare timer.

---
 rtl/cpu_param.sv | 38 +++
 rtl/cp0_ctrl_if.sv | 30 +++
 rtl/cp0_timer.sv | 49 ++++
 rtl/cp0_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/cpu_param.sv
// Shared CPU parameter package: CP0 register numbers, SR/Cause bit positions,
// ExcCode values and the EPC computation used on handler entry.
package cpu_param;

  // CP0 register numbers as seen by mtc0/mfc0
  typedef enum logic [4:0] {
    CP0_COUNT   = 5'd9,
    CP0_COMPARE = 5'd11,
    CP0_SR      = 5'd12,
    CP0_CAUSE   = 5'd13,
    CP0_EPC     = 5'd14,
    CP0_PRID    = 5'd15
  } cp0_reg_e;

  // ExcCode values written into Cause[6:2]
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Bit positions inside SR and Cause
  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int IM_LO       = 10;
  localparam int CAUSE_BD    = 31;
  localparam int EXC_CODE_LO = 2;

  // Return address for the handler: word-aligned PC, backed up one
  // instruction when the faulting instruction sits in a delay slot so that
  // eret re-executes the branch. Wraps modulo 2^32.
  function automatic logic [31:0] epc_calc(input logic [31:0] pc, input logic bd);
    return (pc & 32'hFFFF_FFFC) - (bd ? 32'd4 : 32'd0);
  endfunction

endpackage

// File: rtl/cp0_ctrl_if.sv
// M-stage <-> CP0 bus: exception/interrupt requests, mtc0/mfc0 access, eret,
// and the handler-entry request / EPC returned to the PC logic.
interface cp0_ctrl_if #(
  parameter int NUM_HWINT = 6
);
  logic [31:0]          pc_m;
  logic                 bd_m;
  logic                 exc_valid;
  logic [4:0]           exc_code;
  logic [NUM_HWINT-1:0] hwint;
  logic                 we;
  logic [4:0]           addr;
  logic [31:0]          wdata;
  logic                 eret;
  logic [31:0]          rdata;
  logic                 exc_req;
  logic [31:0]          epc_out;

  // Pipeline side
  modport master (
    output pc_m, bd_m, exc_valid, exc_code, hwint, we, addr, wdata, eret,
    input  rdata, exc_req, epc_out
  );

  // Coprocessor side
  modport slave (
    input  pc_m, bd_m, exc_valid, exc_code, hwint, we, addr, wdata, eret,
    output rdata, exc_req, epc_out
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0. Only present when CP0_TIMER_EN is defined.
// tip is asserted combinationally the cycle Count equals Compare and is then
// held sticky until Compare is rewritten.
`ifdef CP0_TIMER_EN
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we_count,
  input  logic        i_we_compare,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_tip
);
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_tip;
  logic        w_match;

  assign w_match   = (r_count == r_compare);
  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_tip     = r_tip | w_match;

  // Free-running counter; an mtc0 load replaces that cycle's increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 32'd0;
    end else if (i_we_count) begin
      r_count <= i_wdata;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end

  // Compare register and sticky match flag; writing Compare acknowledges it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_compare <= 32'hFFFF_FFFF;
      r_tip     <= 1'b0;
    end else if (i_we_compare) begin
      r_compare <= i_wdata;
      r_tip     <= 1'b0;
    end else if (w_match) begin
      r_tip     <= 1'b1;
    end
  end
endmodule
`endif

// File: rtl/cp0_ctrl.sv
// Coprocessor 0: SR, Cause, EPC, PRId; interrupt/exception arbitration.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_ctrl
  import cpu_param::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID_VAL  = 32'h1817_1906,
  parameter logic [31:0] EPC_RESET = 32'h0000_0000
) (
  input logic        clk,
  input logic        reset,
  cp0_ctrl_if.slave  bus
);
  logic [NUM_HWINT-1:0] r_im;
  logic                 r_exl;
  logic                 r_ie;
  logic                 r_bd;
  logic [NUM_HWINT-1:0] r_ip;
  logic [4:0]           r_exc_code;
  logic [31:0]          r_epc;

  logic [NUM_HWINT-1:0] w_hw;
  logic                 w_int_req;
  logic                 w_exc_take;
  logic                 w_exc_req;
  logic                 w_we_sr;
  logic                 w_we_epc;
  logic [31:0]          w_sr;
  logic [31:0]          w_cause;

`ifdef CP0_TIMER_EN
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_tip;

  // A flushed mtc0 must not touch the timer either
  cp0_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .i_we_count   (bus.we & ~w_exc_req & (bus.addr == CP0_COUNT)),
    .i_we_compare (bus.we & ~w_exc_req & (bus.addr == CP0_COMPARE)),
    .i_wdata      (bus.wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_tip        (w_tip)
  );

  // Timer interrupt shares the top implemented line, ahead of IM masking
  assign w_hw = bus.hwint | (NUM_HWINT'(w_tip) << (NUM_HWINT - 1));
`else
  assign w_hw = bus.hwint;
`endif

  assign w_int_req   = (|(w_hw & r_im)) & r_ie & ~r_exl;
  assign w_exc_take  = bus.exc_valid & ~r_exl;
  assign w_exc_req   = w_int_req | w_exc_take;
  // Gated by reset so a pending request drops as soon as reset asserts
  assign bus.exc_req = w_exc_req & reset;
  assign bus.epc_out = r_epc;

  // mtc0 only lands when the instruction is not being flushed
  assign w_we_sr  = bus.we & ~w_exc_req & (bus.addr == CP0_SR);
  assign w_we_epc = bus.we & ~w_exc_req & (bus.addr == CP0_EPC);

  // Assemble architectural SR and Cause views; unimplemented bits read 0
  always_comb begin
    w_sr                                = '0;
    w_sr[IM_LO +: NUM_HWINT]            = r_im;
    w_sr[SR_EXL]                        = r_exl;
    w_sr[SR_IE]                         = r_ie;
    w_cause                             = '0;
    w_cause[CAUSE_BD]                   = r_bd;
    w_cause[IM_LO +: NUM_HWINT]         = r_ip;
    w_cause[EXC_CODE_LO +: 5]           = r_exc_code;
  end

  // mfc0 read mux; same-cycle mtc0 is deliberately not forwarded
  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      CP0_SR:      bus.rdata = w_sr;
      CP0_CAUSE:   bus.rdata = w_cause;
      CP0_EPC:     bus.rdata = r_epc;
      CP0_PRID:    bus.rdata = PRID_VAL;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   bus.rdata = w_count;
      CP0_COMPARE: bus.rdata = w_compare;
`endif
      default:     bus.rdata = '0;
    endcase
  end

  // Architectural state: handler entry beats eret/mtc0, which are flushed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= EPC_RESET;
    end else begin
      r_ip <= w_hw;
      if (w_exc_req) begin
        r_exl      <= 1'b1;
        r_bd       <= bus.bd_m;
        r_exc_code <= w_int_req ? EXC_INT : bus.exc_code;
        r_epc      <= epc_calc(bus.pc_m, bus.bd_m);
      end else begin
        if (w_we_sr) begin
          r_im  <= bus.wdata[IM_LO +: NUM_HWINT];
          r_ie  <= bus.wdata[SR_IE];
          r_exl <= bus.eret ? 1'b0 : bus.wdata[SR_EXL];
        end else if (bus.eret) begin
          r_exl <= 1'b0;
        end
        if (w_we_epc) begin
          r_epc <= bus.wdata;
        end
      end
    end
  end
endmodule
